// File: rtl/dds_phase_accum.sv
// -----------------------------------------------------------------------------
// dds_phase_accum
//   Phase accumulator stage of the DDS chain, feeding the mode filter.
//   Each enabled cycle the accumulator advances by the frequency tuning word;
//   the top ADDR_W bits form the waveform table address. FTW/mode updates are
//   taken over a valid/ready handshake. While running they are parked in
//   pending registers and committed only at a phase wrap, so the downstream
//   waveform never changes mid-period.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   Enable_i     1 = accumulate each cycle, 0 = hold phase
//   Ftw_i        new frequency tuning word
//   Mode_i       new waveform mode, captured together with Ftw_i
//   Upd_valid_i  update request
//   Upd_ready_o  update accepted when Upd_valid_i & Upd_ready_o
//   Phase_clr_i  synchronous phase clear (also commits any pending update)
//   Phase_off_i  address offset (only when DDS_PHASE_OFFSET_EN is defined)
//   Address_o    registered table address
//   Mode_o       active mode, aligned with Address_o
//   Wrap_o       one-cycle pulse on accumulator carry-out
//   Valid_o      registered Enable_i
//
// Build option
//   DDS_PHASE_OFFSET_EN : adds Phase_off_i; Address_o = top acc bits + offset
//                         (mod 2^ADDR_W). Wrap_o still follows the acc carry.
// -----------------------------------------------------------------------------
module dds_phase_accum #(
   parameter int ACC_W  = 32,
   parameter int ADDR_W = 11,
   parameter int MODE_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              Enable_i,
   input  logic [ACC_W-1:0]  Ftw_i,
   input  logic [MODE_W-1:0] Mode_i,
   input  logic              Upd_valid_i,
   output logic              Upd_ready_o,
   input  logic              Phase_clr_i,
`ifdef DDS_PHASE_OFFSET_EN
   input  logic [ADDR_W-1:0] Phase_off_i,
`endif
   output logic [ADDR_W-1:0] Address_o,
   output logic [MODE_W-1:0] Mode_o,
   output logic              Wrap_o,
   output logic              Valid_o
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PEND
   } state_t;

   state_t            state;
   state_t            state_n;

   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  ftw;
   logic [MODE_W-1:0] mode;
   logic [ACC_W-1:0]  pend_ftw;
   logic [MODE_W-1:0] pend_mode;

   logic [ACC_W:0]    sum;
   logic [ACC_W-1:0]  acc_step;
   logic              wrap;
   logic [ADDR_W-1:0] addr_n;

   logic              accept;
   logic              ld_in;       // load Ftw_i/Mode_i into the active regs now
   logic              ld_pend;     // park Ftw_i/Mode_i in the pending regs
   logic              apply_pend;  // commit pending regs to the active regs

   // ---------------------------------------------------------------------------
   // Datapath: one accumulator step; carry is only meaningful while stepping.
   // ---------------------------------------------------------------------------
   assign sum      = {1'b0, acc} + {1'b0, ftw};
   assign acc_step = Enable_i ? sum[ACC_W-1:0] : acc;
   assign wrap     = Enable_i & sum[ACC_W];

`ifdef DDS_PHASE_OFFSET_EN
   assign addr_n = acc_step[ACC_W-1 -: ADDR_W] + Phase_off_i;
`else
   assign addr_n = acc_step[ACC_W-1 -: ADDR_W];
`endif

   assign Mode_o = mode;

   // ---------------------------------------------------------------------------
   // FSM next-state and update control
   // ---------------------------------------------------------------------------
   always_comb begin
      state_n     = state;
      ld_in       = 1'b0;
      ld_pend     = 1'b0;
      apply_pend  = 1'b0;
      Upd_ready_o = (state != PEND);
      accept      = Upd_valid_i & Upd_ready_o;

      if (Phase_clr_i) begin
         // Clear restarts the period, so any update can take effect right away.
         state_n = Enable_i ? RUN : IDLE;
         if (state == PEND) begin
            apply_pend = 1'b1;
         end else if (accept) begin
            ld_in = 1'b1;
         end
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  ld_in = 1'b1;
               end
               if (Enable_i) begin
                  state_n = RUN;
               end
            end
            RUN: begin
               // A parked update must survive a disable, so PEND wins over IDLE.
               if (accept) begin
                  ld_pend = 1'b1;
                  state_n = PEND;
               end else if (!Enable_i) begin
                  state_n = IDLE;
               end
            end
            PEND: begin
               if (wrap) begin
                  apply_pend = 1'b1;
                  state_n    = RUN;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         ftw       <= '0;
         mode      <= '0;
         pend_ftw  <= '0;
         pend_mode <= '0;
         Address_o <= '0;
         Wrap_o    <= 1'b0;
         Valid_o   <= 1'b0;
      end else begin
         acc       <= Phase_clr_i ? '0 : acc_step;
         Address_o <= Phase_clr_i ? '0 : addr_n;
         Wrap_o    <= ~Phase_clr_i & wrap;
         Valid_o   <= Enable_i;

         // The wrapping step itself still uses the old ftw; new values take
         // effect from the following step.
         if (ld_in) begin
            ftw  <= Ftw_i;
            mode <= Mode_i;
         end else if (apply_pend) begin
            ftw  <= pend_ftw;
            mode <= pend_mode;
         end

         if (ld_pend) begin
            pend_ftw  <= Ftw_i;
            pend_mode <= Mode_i;
         end
      end
   end

endmodule

// File: tb/tb_dds_phase_accum.sv
// -----------------------------------------------------------------------------
// tb_dds_phase_accum
//   Self-checking bench for dds_phase_accum: a directed vector table, directed
//   multi-cycle sequences, and randomized traffic checked against a
//   behavioural model of the phase accumulator.
// -----------------------------------------------------------------------------
module tb_dds_phase_accum;

   localparam int ACC_W  = 32;
   localparam int ADDR_W = 11;
   localparam int MODE_W = 3;
   localparam longint unsigned MOD = 64'h1_0000_0000;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              Enable_i;
   logic [ACC_W-1:0]  Ftw_i;
   logic [MODE_W-1:0] Mode_i;
   logic              Upd_valid_i;
   logic              Upd_ready_o;
   logic              Phase_clr_i;
`ifdef DDS_PHASE_OFFSET_EN
   logic [ADDR_W-1:0] Phase_off_i;
`endif
   logic [ADDR_W-1:0] Address_o;
   logic [MODE_W-1:0] Mode_o;
   logic              Wrap_o;
   logic              Valid_o;

   always #5 clk = ~clk;

   dds_phase_accum #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .MODE_W(MODE_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .Enable_i    (Enable_i),
      .Ftw_i       (Ftw_i),
      .Mode_i      (Mode_i),
      .Upd_valid_i (Upd_valid_i),
      .Upd_ready_o (Upd_ready_o),
      .Phase_clr_i (Phase_clr_i),
`ifdef DDS_PHASE_OFFSET_EN
      .Phase_off_i (Phase_off_i),
`endif
      .Address_o   (Address_o),
      .Mode_o      (Mode_o),
      .Wrap_o      (Wrap_o),
      .Valid_o     (Valid_o)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model: phase as an integer modulo 2^32, an optional parked
   // update, and a "running" flag telling whether updates get parked.
   // ---------------------------------------------------------------------------
   longint unsigned m_acc, m_ftw, m_pftw;
   int unsigned     m_mode, m_pmode, m_addr;
   bit              m_pend, m_run, m_wrap, m_valid;

   task automatic model_reset();
      m_acc = 0; m_ftw = 0; m_pftw = 0;
      m_mode = 0; m_pmode = 0; m_addr = 0;
      m_pend = 0; m_run = 0; m_wrap = 0; m_valid = 0;
   endtask

   task automatic model_step();
      longint unsigned total;
      int unsigned     off;
      bit              take;
      off = 0;
`ifdef DDS_PHASE_OFFSET_EN
      off = Phase_off_i;
`endif
      total = m_acc + m_ftw;
      take  = Upd_valid_i && !m_pend;
      m_valid = Enable_i;
      if (Phase_clr_i) begin
         if (m_pend) begin
            m_ftw = m_pftw; m_mode = m_pmode;
         end else if (take) begin
            m_ftw = Ftw_i; m_mode = Mode_i;
         end
         m_pend = 0;
         m_acc  = 0;
         m_wrap = 0;
         m_addr = 0;
      end else begin
         m_wrap = Enable_i && (total >= MOD);
         if (Enable_i) m_acc = total % MOD;
         if (m_pend) begin
            if (m_wrap) begin
               m_ftw = m_pftw; m_mode = m_pmode; m_pend = 0;
            end
         end else if (take) begin
            if (m_run) begin
               m_pftw = Ftw_i; m_pmode = Mode_i; m_pend = 1;
            end else begin
               m_ftw = Ftw_i; m_mode = Mode_i;
            end
         end
         m_addr = ((m_acc >> (ACC_W - ADDR_W)) + off) % (1 << ADDR_W);
      end
      m_run = m_pend ? 1'b1 : Enable_i;
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic compare_model(input string tag);
      chk({tag, ".addr"},  Address_o,   m_addr);
      chk({tag, ".mode"},  Mode_o,      m_mode);
      chk({tag, ".wrap"},  Wrap_o,      m_wrap);
      chk({tag, ".valid"}, Valid_o,     m_valid);
      chk({tag, ".ready"}, Upd_ready_o, !m_pend);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic idle_inputs();
      Enable_i = 0; Upd_valid_i = 0; Phase_clr_i = 0; Ftw_i = '0; Mode_i = '0;
   endtask

   // ---------------------------------------------------------------------------
   // Directed vector table (starts right after reset, default offset 0)
   // ---------------------------------------------------------------------------
   typedef struct {
      bit          en;
      bit          upd;
      logic [31:0] ftw;
      logic [2:0]  mode;
      bit          clr;
      int unsigned e_addr;
      int unsigned e_mode;
      bit          e_wrap;
      bit          e_valid;
      bit          e_ready;
   } vec_t;

   vec_t vt[13];

   initial begin
      vt[0]  = '{0, 1, 32'h0020_0000, 3'd1, 0,    0, 1, 0, 0, 1};
      vt[1]  = '{1, 0, 32'h0,         3'd0, 0,    1, 1, 0, 1, 1};
      vt[2]  = '{1, 0, 32'h0,         3'd0, 0,    2, 1, 0, 1, 1};
      vt[3]  = '{1, 1, 32'h8000_0000, 3'd5, 0,    3, 1, 0, 1, 0};
      vt[4]  = '{0, 0, 32'h0,         3'd0, 0,    3, 1, 0, 0, 0};
      vt[5]  = '{1, 0, 32'h0,         3'd0, 1,    0, 5, 0, 1, 1};
      vt[6]  = '{1, 0, 32'h0,         3'd0, 0, 1024, 5, 0, 1, 1};
      vt[7]  = '{1, 0, 32'h0,         3'd0, 0,    0, 5, 1, 1, 1};
      vt[8]  = '{1, 1, 32'h0,         3'd2, 0, 1024, 5, 0, 1, 0};
      vt[9]  = '{1, 0, 32'h0,         3'd0, 0,    0, 2, 1, 1, 1};
      vt[10] = '{1, 0, 32'h0,         3'd0, 0,    0, 2, 0, 1, 1};
      vt[11] = '{0, 1, 32'h0010_0000, 3'd7, 0,    0, 2, 0, 0, 0};
      vt[12] = '{0, 0, 32'h0,         3'd0, 1,    0, 7, 0, 0, 1};

      idle_inputs();
`ifdef DDS_PHASE_OFFSET_EN
      Phase_off_i = '0;
`endif
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst.addr",  Address_o,   0);
      chk("rst.mode",  Mode_o,      0);
      chk("rst.wrap",  Wrap_o,      0);
      chk("rst.valid", Valid_o,     0);
      chk("rst.ready", Upd_ready_o, 1);
      rst_n = 1'b1;

      // ---- table ------------------------------------------------------------
      for (int i = 0; i < 13; i++) begin
         Enable_i    = vt[i].en;
         Upd_valid_i = vt[i].upd;
         Ftw_i       = vt[i].ftw;
         Mode_i      = vt[i].mode;
         Phase_clr_i = vt[i].clr;
         cycle();
         chk($sformatf("vec%0d.addr", i),  Address_o,   vt[i].e_addr);
         chk($sformatf("vec%0d.mode", i),  Mode_o,      vt[i].e_mode);
         chk($sformatf("vec%0d.wrap", i),  Wrap_o,      vt[i].e_wrap);
         chk($sformatf("vec%0d.valid", i), Valid_o,     vt[i].e_valid);
         chk($sformatf("vec%0d.ready", i), Upd_ready_o, vt[i].e_ready);
      end
      idle_inputs();

      // ---- full period, then update parked until wrap -------------------------
      do_reset();
      Upd_valid_i = 1; Ftw_i = 32'h0020_0000; Mode_i = 3'd1;
      cycle();
      chk("idle_load.mode", Mode_o, 1);
      chk("idle_load.addr", Address_o, 0);
      Upd_valid_i = 0; Enable_i = 1;
      for (int i = 1; i <= 2048; i++) begin
         cycle();
         chk("ramp.addr", Address_o, i % 2048);
         chk("ramp.wrap", Wrap_o, (i == 2048));
      end
      for (int i = 1; i <= 100; i++) cycle();
      chk("at100.addr", Address_o, 100);
      Upd_valid_i = 1; Ftw_i = 32'h0040_0000; Mode_i = 3'd3;
      cycle();
      Upd_valid_i = 0;
      chk("park.addr",  Address_o, 101);
      chk("park.ready", Upd_ready_o, 0);
      for (int k = 102; k <= 2047; k++) begin
         cycle();
         if (Address_o !== k[ADDR_W-1:0] || Upd_ready_o !== 1'b0 || Mode_o !== 3'd1)
            chk("pend.run", {Address_o, Upd_ready_o, Mode_o}, {k[ADDR_W-1:0], 1'b0, 3'd1});
      end
      cycle();
      chk("commit.addr",  Address_o, 0);
      chk("commit.mode",  Mode_o, 3);
      chk("commit.wrap",  Wrap_o, 1);
      chk("commit.ready", Upd_ready_o, 1);
      for (int i = 1; i <= 3; i++) begin
         cycle();
         chk("double.addr", Address_o, 2 * i);
      end
      compare_model("seqA");

      // ---- phase clear with a parked update -----------------------------------
      idle_inputs();
      do_reset();
      Upd_valid_i = 1; Ftw_i = 32'h0020_0000; Mode_i = 3'd1;
      cycle();
      Upd_valid_i = 0; Enable_i = 1;
      for (int i = 1; i <= 500; i++) cycle();
      chk("at500.addr", Address_o, 500);
      Upd_valid_i = 1; Ftw_i = 32'h0010_0000; Mode_i = 3'd2;
      cycle();
      Upd_valid_i = 0;
      chk("clrpark.ready", Upd_ready_o, 0);
      Phase_clr_i = 1;
      cycle();
      Phase_clr_i = 0;
      chk("clr.addr",  Address_o, 0);
      chk("clr.mode",  Mode_o, 2);
      chk("clr.ready", Upd_ready_o, 1);
      chk("clr.wrap",  Wrap_o, 0);
      for (int i = 1; i <= 8; i++) begin
         cycle();
         chk("half.addr", Address_o, i / 2);
      end
      compare_model("seqB");

      // ---- asynchronous reset mid-PEND ----------------------------------------
      idle_inputs();
      do_reset();
      Upd_valid_i = 1; Ftw_i = 32'h0020_0000; Mode_i = 3'd4;
      cycle();
      Enable_i = 1; Ftw_i = 32'h0030_0000; Mode_i = 3'd6;
      for (int i = 0; i < 10; i++) begin
         Upd_valid_i = (i == 9);
         cycle();
      end
      Upd_valid_i = 0;
      chk("pre_rst.ready", Upd_ready_o, 0);
      chk("pre_rst.mode",  Mode_o, 4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.addr",  Address_o, 0);
      chk("arst.mode",  Mode_o, 0);
      chk("arst.valid", Valid_o, 0);
      chk("arst.ready", Upd_ready_o, 1);
      #1;
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         cycle();
         compare_model("post_rst");
      end
      chk("lost.mode", Mode_o, 0);
      chk("lost.addr", Address_o, 0);

`ifdef DDS_PHASE_OFFSET_EN
      // ---- address offset: wrap follows the carry, not Address_o == 0 --------
      idle_inputs();
      do_reset();
      Phase_off_i = 11'd1024;
      Upd_valid_i = 1; Ftw_i = 32'h0020_0000; Mode_i = 3'd1;
      cycle();
      Upd_valid_i = 0; Enable_i = 1;
      for (int i = 1; i <= 2050; i++) begin
         cycle();
         chk("off.addr", Address_o, (i + 1024) % 2048);
         chk("off.wrap", Wrap_o, (i == 2048));
      end
`endif

      // ---- randomized traffic against the model -------------------------------
      idle_inputs();
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         Enable_i    = ($urandom_range(0, 9) != 0);
         Upd_valid_i = ($urandom_range(0, 11) == 0);
         Phase_clr_i = ($urandom_range(0, 79) == 0);
         Mode_i      = MODE_W'($urandom);
         case ($urandom_range(0, 3))
            0: Ftw_i = '0;
            1: Ftw_i = $urandom;
            2: Ftw_i = 32'h4000_0000 + ($urandom & 32'hFFFF);
            default: Ftw_i = $urandom & 32'h0FFF_FFFF;
         endcase
`ifdef DDS_PHASE_OFFSET_EN
         Phase_off_i = ADDR_W'($urandom);
`endif
         cycle();
         compare_model("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
